// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: IR field layout, opcodes,
// state encoding and ALU strobe decode.
package control_sequencer_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef logic [4:0] opcode_t;

  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_NEG  = 5'b10001;
  localparam opcode_t OP_NOT  = 5'b10010;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4,
    ST_T4   = 3'd5,
    ST_T5   = 3'd6,
    ST_HALT = 3'd7
  } state_e;

  function automatic logic is_binary(input opcode_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_unary(input opcode_t op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // Strobe order matches the port group {AND, OR, ADD, SUB, NEG, NOT}.
  function automatic logic [5:0] alu_strobe(input opcode_t op);
    logic [5:0] s;
    case (op)
      OP_AND:  s = 6'b100000;
      OP_OR:   s = 6'b010000;
      OP_ADD:  s = 6'b001000;
      OP_SUB:  s = 6'b000100;
      OP_NEG:  s = 6'b000010;
      OP_NOT:  s = 6'b000001;
      default: s = 6'b000000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/reg_decoder_4to16.sv
// 4-to-16 one-hot register select decoder; all zero when disabled.
module reg_decoder_4to16 (
  input  logic        i_en,
  input  logic [3:0]  i_sel,
  output logic [15:0] o_onehot
);

  assign o_onehot = i_en ? (16'h0001 << i_sel) : 16'h0000;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch in T0-T2, execute ALU/NOP/HALT from T3,
// outputs are a Moore decode of the state register and IR fields.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Run,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        IncPC,
  output logic        Read,
  output logic        AND,
  output logic        OR,
  output logic        ADD,
  output logic        SUB,
  output logic        NEG,
  output logic        NOT,
  output logic [15:0] Rout_sel,
  output logic [15:0] Rin_sel,
  output logic        Done,
  output logic        Halted
);

  state_e      r_state;
  opcode_t     w_opcode;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic        w_binary;
  logic        w_unary;
  logic        w_rout_en;
  logic [3:0]  w_rout_idx;
  logic        w_rin_en;
  logic        w_unused_ir;

  assign w_opcode    = IR[OPC_MSB:OPC_LSB];
  assign w_ra        = IR[RA_MSB:RA_LSB];
  assign w_rb        = IR[RB_MSB:RB_LSB];
  assign w_rc        = IR[RC_MSB:RC_LSB];
  assign w_binary    = is_binary(w_opcode);
  assign w_unary     = is_unary(w_opcode);
  assign w_unused_ir = ^IR[RC_LSB-1:0];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= Run ? ST_T0 : ST_IDLE;
        ST_T0:   r_state <= ST_T1;
        ST_T1:   r_state <= ST_T2;
        ST_T2:   r_state <= ST_T3;
        ST_T3: begin
          // Anything that is neither an ALU op nor NOP stops the machine.
          if (w_binary || w_unary) begin
            r_state <= ST_T4;
          end else if (w_opcode == OP_NOP) begin
            r_state <= Run ? ST_T0 : ST_IDLE;
          end else begin
            r_state <= ST_HALT;
          end
        end
        ST_T4:   r_state <= ST_T5;
        ST_T5:   r_state <= Run ? ST_T0 : ST_IDLE;
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read} = 11'b0;
    {AND, OR, ADD, SUB, NEG, NOT} = 6'b000000;
    Done       = 1'b0;
    Halted     = 1'b0;
    w_rout_en  = 1'b0;
    w_rout_idx = 4'd0;
    w_rin_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        Done = 1'b0;
      end
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: begin
        if (w_binary) begin
          w_rout_en  = 1'b1;
          w_rout_idx = w_rb;
          Yin        = 1'b1;
        end else if (w_opcode == OP_NOP) begin
          Done = 1'b1;
        end else begin
          Done = 1'b0;
        end
      end
      ST_T4: begin
        // Binary ops put Rc on the bus (Rb already in Y); unary ops use Rb directly.
        w_rout_en  = 1'b1;
        w_rout_idx = w_binary ? w_rc : w_rb;
        Zin        = 1'b1;
        {AND, OR, ADD, SUB, NEG, NOT} = alu_strobe(w_opcode);
      end
      ST_T5: begin
        Zlowout  = 1'b1;
        w_rin_en = 1'b1;
        Done     = 1'b1;
      end
      ST_HALT: begin
        Halted = 1'b1;
      end
      default: begin
        Halted = 1'b0;
      end
    endcase
  end

  reg_decoder_4to16 u_rout_dec (
    .i_en     (w_rout_en),
    .i_sel    (w_rout_idx),
    .o_onehot (Rout_sel)
  );

  reg_decoder_4to16 u_rin_dec (
    .i_en     (w_rin_en),
    .i_sel    (w_ra),
    .o_onehot (Rin_sel)
  );

endmodule
